// File: rtl/plab4_net_router_output_sched.sv
// Output-port scheduler for one router output: round-robin packet arbitration over
// three inputs with wormhole locking and fixed dead time on security-domain changes.
module plab4_net_router_output_sched #(
    parameter int p_switch_lat = 2,
    parameter int p_cnt_w      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] reqs,
    input  logic [2:0] req_domains,
    input  logic [2:0] req_tails,
    input  logic       out_rdy,
    output logic [2:0] grants,
    output logic       out_val,
    output logic [1:0] xbar_sel,
    output logic       out_domain,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    localparam logic [p_cnt_w-1:0] SW_INIT = p_cnt_w'(p_switch_lat - 1);

    state_e             state_q, state_d;
    logic [1:0]         prio_q, prio_d;
    logic [1:0]         lock_q, lock_d;
    logic [1:0]         pend_q, pend_d;
    logic [p_cnt_w-1:0] cnt_q, cnt_d;
    logic               dom_q, dom_d;
    logic [1:0]         last_sel_q, last_sel_d;

    logic [1:0] scan1_s, scan2_s;
    logic       win_vld_s;
    logic [1:0] win_s;
    logic       try_s;
    logic [1:0] port_s;
    logic       xfer_s;

    // Modulo-3 increment; port index 3 never occurs.
    function automatic logic [1:0] inc3(input logic [1:0] p);
        case (p)
            2'd0:    inc3 = 2'd1;
            2'd1:    inc3 = 2'd2;
            default: inc3 = 2'd0;
        endcase
    endfunction

    // Round-robin winner starting at the priority pointer
    always_comb begin
        scan1_s   = inc3(prio_q);
        scan2_s   = inc3(scan1_s);
        win_vld_s = 1'b0;
        win_s     = 2'd0;
        if (reqs[prio_q]) begin
            win_vld_s = 1'b1;
            win_s     = prio_q;
        end else if (reqs[scan1_s]) begin
            win_vld_s = 1'b1;
            win_s     = scan1_s;
        end else if (reqs[scan2_s]) begin
            win_vld_s = 1'b1;
            win_s     = scan2_s;
        end else begin
            win_vld_s = 1'b0;
            win_s     = 2'd0;
        end
    end

    // Candidate grant: try_s means a grant would issue if out_rdy were high
    always_comb begin
        try_s  = 1'b0;
        port_s = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s && (req_domains[win_s] == dom_q)) begin
                    try_s  = 1'b1;
                    port_s = win_s;
                end else begin
                    try_s  = 1'b0;
                    port_s = 2'd0;
                end
            end
            ST_LOCKED: begin
                if (reqs[lock_q]) begin
                    try_s  = 1'b1;
                    port_s = lock_q;
                end else begin
                    try_s  = 1'b0;
                    port_s = 2'd0;
                end
            end
            default: begin
                try_s  = 1'b0;
                port_s = 2'd0;
            end
        endcase
    end

    assign xfer_s     = try_s & out_rdy & ~reset;
    assign grants     = xfer_s ? (3'b001 << port_s) : 3'b000;
    assign out_val    = |grants;
    assign xbar_sel   = try_s ? port_s : last_sel_q;
    assign out_domain = dom_q;
    assign busy       = (state_q != ST_IDLE);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_d     = lock_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        dom_d      = dom_q;
        last_sel_d = xfer_s ? port_s : last_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (!win_vld_s) begin
                    state_d = ST_IDLE;
                end else if (req_domains[win_s] != dom_q) begin
                    pend_d  = win_s;
                    cnt_d   = SW_INIT;
                    state_d = ST_SWITCH;
                end else if (out_rdy) begin
                    if (req_tails[win_s]) begin
                        prio_d = inc3(win_s);
                    end else begin
                        lock_d  = win_s;
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && req_tails[lock_q]) begin
                    prio_d  = inc3(lock_q);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_SWITCH: begin
                if (cnt_q != {p_cnt_w{1'b0}}) begin
                    cnt_d = cnt_q - {{(p_cnt_w-1){1'b0}}, 1'b1};
                end else begin
                    dom_d   = req_domains[pend_q];
                    prio_d  = pend_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_q     <= 2'd0;
            lock_q     <= 2'd0;
            pend_q     <= 2'd0;
            cnt_q      <= {p_cnt_w{1'b0}};
            dom_q      <= 1'b0;
            last_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            dom_q      <= dom_d;
            last_sel_q <= last_sel_d;
        end
    end

endmodule
